// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between instruction fetch and load/store.
// Optional feature: `MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking instead of data priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_enable,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]   pmem_wdata,
    output logic [DATA_W/8-1:0] pmem_byte_enable,
    input  logic [DATA_W-1:0]   pmem_rdata,
    input  logic                pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;
    logic   tie_to_d;

    assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic INSTR = 1'b0;
    localparam logic DATA  = 1'b1;
    logic last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= INSTR;
        end else if (grant_d) begin
            last_grant <= DATA;
        end else if (grant_i) begin
            last_grant <= INSTR;
        end
    end

    // A tie goes to whichever side did not win last; after reset that is data.
    assign tie_to_d = (last_grant == INSTR);
`else
    assign tie_to_d = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = D_BUSY;
                end else if (grant_i) begin
                    state_next = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grants are only decided in IDLE; requester inputs are ignored while busy.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_read || tie_to_d)) begin
                    grant_d = 1'b1;
                end else if (i_read) begin
                    grant_i = 1'b1;
                end
            end
            I_BUSY:  i_resp = pmem_resp;
            D_BUSY:  d_resp = pmem_resp;
            default: ;
        endcase
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // A simultaneous read and write from the data side is served as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= '1;
        end else if (grant_d) begin
            pmem_read        <= ~d_write;
            pmem_write       <= d_write;
            pmem_address     <= d_address;
            pmem_wdata       <= d_wdata;
            pmem_byte_enable <= d_write ? d_byte_enable : '1;
        end else if (grant_i) begin
            pmem_read        <= 1'b1;
            pmem_write       <= 1'b0;
            pmem_address     <= i_address;
            pmem_byte_enable <= '1;
        end else if (state != IDLE && pmem_resp) begin
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, a behavioural memory, and queue-based
// monitors for memory-port grants and requester responses.
module tb_mem_arbiter;

    localparam int MEM_LAT = 3;
    localparam int TXN_W   = 70;
    localparam int RESP_W  = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    logic        auto_resp;
    logic        manual_resp;
    logic        mem_auto;
    logic [31:0] mem [0:63];
    int          mem_cnt;

    int checks = 0;
    int failures = 0;
    int txn_count = 0;

    logic [TXN_W-1:0]  exp_txn_q[$];
    logic [RESP_W-1:0] exp_resp_q[$];

    assign pmem_resp = auto_resp | manual_resp;

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .i_read           (i_read),
        .i_address        (i_address),
        .i_rdata          (i_rdata),
        .i_resp           (i_resp),
        .d_read           (d_read),
        .d_write          (d_write),
        .d_address        (d_address),
        .d_wdata          (d_wdata),
        .d_byte_enable    (d_byte_enable),
        .d_rdata          (d_rdata),
        .d_resp           (d_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(string name, logic [TXN_W-1:0] act, logic [TXN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [TXN_W-1:0] txn(logic w, logic r, logic [3:0] be,
                                              logic [31:0] a, logic [31:0] d);
        return {w, r, be, a, (w ? d : 32'h0)};
    endfunction

    // Behavioural memory: answers MEM_LAT cycles after the strobe first appears.
    initial begin
        auto_resp  = 1'b0;
        pmem_rdata = '0;
        mem_cnt    = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[6'h18] = 32'h0000_0013;
        forever begin
            @(posedge clk);
            #1;
            auto_resp = 1'b0;
            if (mem_auto && (pmem_read || pmem_write)) begin
                if (mem_cnt == MEM_LAT) begin
                    auto_resp = 1'b1;
                    mem_cnt   = 0;
                    if (pmem_write) begin
                        for (int b = 0; b < 4; b++)
                            if (pmem_byte_enable[b])
                                mem[pmem_address[7:2]][8*b +: 8] = pmem_wdata[8*b +: 8];
                    end else begin
                        pmem_rdata = mem[pmem_address[7:2]];
                    end
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Monitor: every new memory-port transaction must match the next expected grant.
    initial begin
        logic prev_strobe;
        logic [TXN_W-1:0] e;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if ((pmem_read || pmem_write) && !prev_strobe) begin
                txn_count++;
                if (exp_txn_q.size() == 0) begin
                    check("txn_unexpected", {pmem_write, pmem_read}, 2'b00);
                end else begin
                    e = exp_txn_q.pop_front();
                    check("txn", txn(pmem_write, pmem_read, pmem_byte_enable,
                                     pmem_address, pmem_wdata), e);
                end
            end
            prev_strobe = pmem_read | pmem_write;
        end
    end

    // Monitor: every response pulse must go to the expected owner with the expected data.
    initial begin
        logic [RESP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                if (exp_resp_q.size() == 0) begin
                    check("resp_unexpected", {i_resp, d_resp}, 2'b00);
                end else begin
                    e = exp_resp_q.pop_front();
                    check("resp_owner", {i_resp, d_resp}, {~e[32], e[32]});
                    if (e[33]) check("resp_data", e[32] ? d_rdata : i_rdata, e[31:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic expect_fetch(input logic [31:0] a, input logic [31:0] d);
        exp_txn_q.push_back(txn(1'b0, 1'b1, 4'hf, a, 32'h0));
        exp_resp_q.push_back({1'b1, 1'b0, d});
    endtask

    task automatic expect_load(input logic [31:0] a, input logic [31:0] d);
        exp_txn_q.push_back(txn(1'b0, 1'b1, 4'hf, a, 32'h0));
        exp_resp_q.push_back({1'b1, 1'b1, d});
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_txn_q.push_back(txn(1'b1, 1'b0, be, a, d));
        exp_resp_q.push_back({1'b0, 1'b1, 32'h0});
    endtask

    task automatic wait_resp(input logic is_d, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(is_d ? d_resp : i_resp) && n < 50);
        check(is_d ? "d_resp_seen" : "i_resp_seen", is_d ? d_resp : i_resp, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic data_access(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be);
        int n;
        d_read = rd; d_write = wr; d_address = a; d_wdata = d; d_byte_enable = be;
        wait_resp(1'b1, n);
        check("data_latency", n, 1 + MEM_LAT);
        d_read = 1'b0; d_write = 1'b0;
        @(posedge clk);
        #2;
    endtask

    // Stimulus
    initial begin
        int n;
        int base;
        logic win_d [3];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_d = '{1'b1, 1'b0, 1'b1};
`else
        win_d = '{1'b1, 1'b1, 1'b1};
`endif
        rst = 1'b1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
        d_address = 0; d_wdata = 0; d_byte_enable = 0;
        manual_resp = 1'b0; mem_auto = 1'b1;
        @(posedge clk);
        #2;
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_pmem_wdata", pmem_wdata, 32'h0);
        check("rst_pmem_be", pmem_byte_enable, 4'hf);
        check("rst_resp", {i_resp, d_resp}, 2'b00);
        do_reset();

        // Single fetch, with the address changing while the fetch is in flight.
        expect_fetch(32'h60, 32'h0000_0013);
        i_read = 1'b1; i_address = 32'h60;
        @(posedge clk);
        #2;
        check("fetch_grant_read", {pmem_read, pmem_write}, 2'b10);
        check("fetch_grant_addr", pmem_address, 32'h60);
        i_address = 32'h64;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            check("fetch_hold_addr", pmem_address, 32'h60);
        end while (!i_resp && n < 20);
        check("fetch_mem_latency", n, MEM_LAT);
        i_read = 1'b0;
        @(posedge clk);
        #2;
        check("fetch_strobe_clear", pmem_read, 1'b0);

        // Store with partial mask, then read it back.
        expect_store(32'h84, 32'hDEADBEEF, 4'b0011);
        d_write = 1'b1; d_address = 32'h84; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
        @(posedge clk);
        #2;
        check("store_strobes", {pmem_read, pmem_write}, 2'b01);
        check("store_be", pmem_byte_enable, 4'b0011);
        check("store_wdata", pmem_wdata, 32'hDEADBEEF);
        wait_resp(1'b1, n);
        d_write = 1'b0;
        @(posedge clk);
        #2;
        expect_load(32'h84, 32'h0000_BEEF);
        data_access(1'b1, 1'b0, 32'h84, 32'h0, 4'h0);

        // Read and write together are served as a write.
        expect_store(32'h88, 32'h12345678, 4'b1010);
        data_access(1'b1, 1'b1, 32'h88, 32'h12345678, 4'b1010);
        expect_load(32'h88, 32'h1200_5600);
        data_access(1'b1, 1'b0, 32'h88, 32'h0, 4'h0);

        // Tie with both held: data first, fetch after one idle cycle.
        do_reset();
        base = txn_count;
        expect_load(32'h84, 32'h0000_BEEF);
        expect_fetch(32'h60, 32'h0000_0013);
        i_read = 1'b1; i_address = 32'h60; d_read = 1'b1; d_address = 32'h84;
        wait_resp(1'b1, n);
        d_read = 1'b0;
        @(posedge clk);
        #2;
        check("tie_idle_gap", pmem_read, 1'b0);
        @(posedge clk);
        #2;
        check("tie_fetch_grant", {pmem_read, pmem_address}, {1'b1, 32'h60});
        wait_resp(1'b0, n);
        i_read = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("tie_txn_count", txn_count - base, 2);

        // Three consecutive ties from reset.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            if (win_d[r]) expect_load(32'h88, 32'h1200_5600);
            else          expect_fetch(32'h60, 32'h0000_0013);
            i_read = 1'b1; i_address = 32'h60; d_read = 1'b1; d_address = 32'h88;
            wait_resp(win_d[r], n);
            i_read = 1'b0; d_read = 1'b0;
            @(posedge clk);
            #2;
        end

        // Reset during D_BUSY, then a stray memory reply while idle.
        mem_auto = 1'b0;
        exp_txn_q.push_back(txn(1'b0, 1'b1, 4'hf, 32'h84, 32'h0));
        d_read = 1'b1; d_address = 32'h84;
        @(posedge clk);
        #2;
        check("rstmid_busy_read", pmem_read, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_strobes", {pmem_read, pmem_write}, 2'b00);
        d_read = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        manual_resp = 1'b1;
        #1;
        check("stray_resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk);
        #2;
        manual_resp = 1'b0;
        mem_auto = 1'b1;

        // Recovery after reset.
        expect_fetch(32'h60, 32'h0000_0013);
        i_read = 1'b1; i_address = 32'h60;
        wait_resp(1'b0, n);
        check("recover_latency", n, 1 + MEM_LAT);
        i_read = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        check("txn_queue_empty", exp_txn_q.size(), 0);
        check("resp_queue_empty", exp_resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single physical memory port between the instruction-fetch side and the load/store side of the RV32I core. Each requester uses the same level request / `mem_resp` pulse handshake the multicycle control FSM already drives. The arbiter:
- grants one requester at a time;
- registers the granted request onto the memory port;
- routes the response back to the owner only.

## Interface
Parameters:
- ADDR_W, 32, address width (rv32i_word).
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_read  in  1  instruction read request, held until i_resp.
- i_address  in  ADDR_W  instruction address.
- i_rdata  out  DATA_W  instruction read data, valid with i_resp.
- i_resp  out  1  one-cycle completion pulse to fetch side.
- d_read  in  1  data read request, held until d_resp.
- d_write  in  1  data write request, held until d_resp.
- d_address  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_byte_enable  in  DATA_W/8  store byte mask (rv32i_mem_wmask).
- d_rdata  out  DATA_W  load data, valid with d_resp.
- d_resp  out  1  one-cycle completion pulse to data side.
- pmem_read  out  1  memory read strobe, registered.
- pmem_write  out  1  memory write strobe, registered.
- pmem_address  out  ADDR_W  registered address.
- pmem_wdata  out  DATA_W  registered store data.
- pmem_byte_enable  out  DATA_W/8  registered mask; 4'b1111 for all reads.
- pmem_rdata  in  DATA_W  memory read data.
- pmem_resp  in  1  memory completion pulse.

## Operation
- **States:** IDLE, I_BUSY, D_BUSY. Reset enters IDLE.
- **IDLE**
  - d request (d_read|d_write) and i_read both high: tie resolved per Configuration.
  - Only one high: that port is granted.
  - On grant, capture the granter's address, wdata, mask and read/write into the pmem_* registers, then enter I_BUSY or D_BUSY.
- **I_BUSY / D_BUSY**
  - pmem_* held constant.
  - Input changes from either requester are ignored.
  - On pmem_resp, pulse the owner's resp for that cycle and return to IDLE. pmem_read/pmem_write clear at the same edge.
- **Data routing**
  - i_rdata = d_rdata = pmem_rdata (pass-through).
  - Only the resp strobes are qualified by state.
- **d_read and d_write both high** is a protocol violation; it is treated as a write.
- **Requester drops its request mid-transaction:** the transaction still completes and resp still pulses.
- **pmem_resp while IDLE:** ignored; neither resp asserts.
- **Reset mid-transaction:** immediate IDLE, all pmem strobes 0, no resp. The in-flight memory reply is discarded as above.

## Timing
- **Reset values:**
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, pmem_byte_enable=4'b1111.
  - i_resp=0, d_resp=0, state IDLE.
  - last_grant=INSTR.
- **Grant latency:** request high in IDLE during cycle t → pmem strobe high in cycle t+1.
- **Response:** i_resp/d_resp are combinational with pmem_resp in the same cycle k. State returns to IDLE at the edge ending k.
- **Back-to-back:** a new grant is possible at the edge ending k+1 at the earliest (IDLE for one cycle). The minimum gap between transactions is one idle cycle.
- **Total requester latency:** 1 + memory latency cycles.
- **Strobe width:** pmem_read/pmem_write never both high. Each is high continuously from grant to pmem_resp.

## Configuration
- **Macro:** `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:**
  - A 1-bit last_grant register updates on every grant.
  - Ties go to the port not most recently granted.
  - The first tie after reset goes to data.
- **Undefined:**
  - Fixed priority: data always wins ties.
  - last_grant is not implemented.
- **Single-requester behaviour** is identical in both builds.

## Test plan
- **Reset mid-operation:** rst asserted mid-D_BUSY → strobes 0 in the same cycle. A later pmem_resp produces no d_resp/i_resp.
- **Single fetch:** i_read=1, i_address=0x60; memory answers 3 cycles after pmem_read, with pmem_rdata=0x00000013.
  - pmem_read=1 and pmem_address=0x60 in the cycle after the request.
  - i_resp pulses once with i_rdata=0x00000013.
  - d_resp stays 0.
- **Store:** d_write=1, d_address=0x84, d_wdata=0xDEADBEEF, d_byte_enable=4'b0011 → pmem_write=1, pmem_byte_enable=4'b0011, pmem_wdata=0xDEADBEEF, pmem_read=0. d_resp pulses once.
- **Tie, fixed priority (macro undefined):** i_read and d_read rise in the same cycle, both held.
  - Data is granted first.
  - One cycle after d_resp, fetch is granted.
  - Exactly 2 pmem transactions occur.
- **Tie, round robin (macro defined):** three consecutive ties → grant order D, I, D.
- **Hold:** i_address changes from 0x60 to 0x64 during I_BUSY → pmem_address stays 0x60 until pmem_resp.
